// File: rtl/adder_chk_pkg.sv
// adder_chk_pkg: shared constants for the adder sweep checker.
// Holds FSM encodings, default WIDTH/SETTLE and the settle counter width.
package adder_chk_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_SETTLE = 2;
  localparam int SETTLE_W   = 4;

endpackage

// File: rtl/adder_sweep_checker_ref_adder.sv
// ref_adder: combinational golden adder, sum = {cout, s}.
// Ports: a, b (WIDTH) in; sum (WIDTH+1) out.
module ref_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_sweep_checker.sv
// adder_sweep_checker: exhaustive sweep of an external adder vs golden sum.
// Ports: clk, rst, start, dut_sum in; op_a/op_b, busy, done, pass, err_count,
// fail_valid, fail_a/fail_b/fail_sum out. HALT_ON_ERROR_EN: stop at 1st miss.
module adder_sweep_checker
  import adder_chk_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH:0]     dut_sum,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b,
  output logic [WIDTH:0]     fail_sum
);

  localparam int VW = 2 * WIDTH;
  localparam int EW = 2 * WIDTH + 1;
  localparam logic [SETTLE_W-1:0] S_LAST =
    SETTLE_W'(SETTLE - 1);

`ifdef HALT_ON_ERROR_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic [1:0]          state;
  logic [VW-1:0]       vcnt;
  logic [SETTLE_W-1:0] scnt;
  logic [WIDTH:0]      gold;
  logic                miss;
  logic                last;
  logic                stop;

  assign op_a = vcnt[VW-1:WIDTH];
  assign op_b = vcnt[WIDTH-1:0];

  ref_adder #(.WIDTH(WIDTH)) u_ref (
    .a   (op_a),
    .b   (op_b),
    .sum (gold)
  );

  assign miss = (dut_sum != gold);
  assign last = &vcnt;
  assign stop = last | (HALT & miss);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      vcnt       <= '0;
      scnt       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_sum   <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_DRIVE;
            vcnt       <= '0;
            scnt       <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_sum   <= '0;
          end
        end
        ST_DRIVE: begin
          if (scnt == S_LAST) begin
            scnt  <= '0;
            state <= ST_CHECK;
          end else begin
            scnt <= scnt + SETTLE_W'(1);
          end
        end
        ST_CHECK: begin
          if (miss) begin
            err_count <= err_count + EW'(1);
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_a     <= op_a;
              fail_b     <= op_b;
              fail_sum   <= dut_sum;
            end
          end
          if (stop) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            // the final vector's outcome is folded in here
            pass  <= (err_count == '0) && !miss;
          end else begin
            vcnt  <= vcnt + VW'(1);
            state <= ST_DRIVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_sweep_checker.sv
// tb_adder_sweep_checker: table, random and corner-case checks of the
// sweep checker against a faultable behavioural adder.
module tb_adder_sweep_checker;

  localparam int W = 4;
  localparam int S = 2;
  localparam int NV = 1 << (2 * W);
  localparam int PER = S + 1;

`ifdef HALT_ON_ERROR_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W:0]   dut_sum;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, pass;
  logic [2*W:0] err_count;
  logic         fail_valid;
  logic [W-1:0] fail_a, fail_b;
  logic [W:0]   fail_sum;

  int   mode;
  bit   bad [NV];
  logic [W:0] mask;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adder_sweep_checker #(.WIDTH(W), .SETTLE(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dut_sum    (dut_sum),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_valid (fail_valid),
    .fail_a     (fail_a),
    .fail_b     (fail_b),
    .fail_sum   (fail_sum)
  );

  // adder under test with selectable faults
  always_comb begin
    dut_sum = {1'b0, op_a} + {1'b0, op_b};
    case (mode)
      1: dut_sum[0] = 1'b0;
      2: dut_sum[W] = 1'b0;
      3: if (bad[{op_a, op_b}]) dut_sum = dut_sum ^ mask;
      default: ;
    endcase
  end

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_pass"}, pass, 0);
    chk({name, "_ops"}, {op_a, op_b}, 0);
    chk({name, "_err"}, err_count, 0);
    chk({name, "_fail"},
        {fail_valid, fail_a, fail_b, fail_sum}, 0);
  endtask

  task automatic run_sweep(input int repulse, output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    chk("acc_busy", busy, 1);
    chk("acc_done", done, 0);
    chk("acc_err_clr", err_count, 0);
    chk("acc_fv_clr", fail_valid, 0);
    chk("acc_ops", {op_a, op_b}, 0);
    while (!done && cyc < 4 * NV * PER) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == repulse);
    end
    start = 1'b0;
    chk("sweep_done", done, 1);
  endtask

  typedef struct {
    int mode;
    int cyc;
    int err;
    int fv;
    int fa;
    int fb;
    int fsum;
    int pass;
    int oa;
    int ob;
  } vec_t;

  vec_t tab [3];

  initial begin
    int cyc;
    int e, first, a, b, good, got;
    int ecyc, eerr, eoa, eob;

    tab[0] = '{0, 768, 0, 0, 0, 0, 0, 1, 15, 15};
    if (HALT) begin
      tab[1] = '{1, 6, 1, 1, 0, 1, 0, 0, 0, 1};
      tab[2] = '{2, 96, 1, 1, 1, 15, 0, 0, 1, 15};
    end else begin
      tab[1] = '{1, 768, 128, 1, 0, 1, 0, 0, 15, 15};
      tab[2] = '{2, 768, 120, 1, 1, 15, 0, 0, 15, 15};
    end

    mode  = 0;
    mask  = '0;
    start = 1'b0;
    rst   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // fault table; each sweep starts from DONE of the previous one
    for (int i = 0; i < 3; i++) begin
      mode = tab[i].mode;
      run_sweep(-1, cyc);
      chk("t_cycles", cyc, tab[i].cyc);
      chk("t_err", err_count, tab[i].err);
      chk("t_fv", fail_valid, tab[i].fv);
      chk("t_fa", fail_a, tab[i].fa);
      chk("t_fb", fail_b, tab[i].fb);
      chk("t_fsum", fail_sum, tab[i].fsum);
      chk("t_pass", pass, tab[i].pass);
      chk("t_opa", op_a, tab[i].oa);
      chk("t_opb", op_b, tab[i].ob);
    end

    // random fault maps checked against a whole-sweep model
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NV; k++)
        bad[k] = ($urandom_range(0, 15) == 0);
      mask = W'(0) + 5'($urandom_range(1, 31));
      mode = 3;
      e = 0;
      first = -1;
      for (int k = 0; k < NV; k++) begin
        a = k / 16;
        b = k % 16;
        good = a + b;
        got = bad[k] ? (good ^ int'(mask)) : good;
        if (got != good) begin
          e++;
          if (first < 0) first = k;
        end
      end
      ecyc = NV * PER;
      eerr = e;
      eoa = 15;
      eob = 15;
      if (HALT && first >= 0) begin
        ecyc = (first + 1) * PER;
        eerr = 1;
        eoa = first / 16;
        eob = first % 16;
      end
      run_sweep(-1, cyc);
      chk("r_cycles", cyc, ecyc);
      chk("r_err", err_count, eerr);
      chk("r_fv", fail_valid, first >= 0);
      chk("r_pass", pass, first < 0);
      chk("r_opa", op_a, eoa);
      chk("r_opb", op_b, eob);
      if (first >= 0) begin
        chk("r_fa", fail_a, first / 16);
        chk("r_fb", fail_b, first % 16);
        chk("r_fsum", fail_sum,
            ((first / 16) + (first % 16)) ^ int'(mask));
      end
    end

    // reset mid-sweep at vector (3,7)
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (!(op_a == 3 && op_b == 7) && cyc < NV * PER) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("mid_reached", {op_a, op_b}, 8'h37);
    rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    run_sweep(-1, cyc);
    chk("post_rst_pass", pass, 1);
    chk("post_rst_cyc", cyc, NV * PER);

    // start re-pulsed mid-sweep is ignored
    run_sweep(100, cyc);
    chk("repulse_cyc", cyc, NV * PER);
    chk("repulse_pass", pass, 1);
    chk("repulse_err", err_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_sweep_checker.md
# adder_sweep_checker

Synthesizable response-side companion to the team's exhaustive adder stimulus. The block sweeps every operand pair of a WIDTH-bit adder in a fixed order, drives the pair to an external adder under test, and waits a programmable settle time. It then compares the adder's (WIDTH+1)-bit sum against an internal golden sum and reports pass/fail, an error count and the first failing vector. It sits beside the adder on the lab board or in a self-checking top, replacing manual inspection of monitor output.

## Interface
- WIDTH, 4: operand width in bits; the sum is WIDTH+1 bits (carry-out is the MSB).
- SETTLE, 2: cycles each vector is held before it is checked; legal range is 1..15.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a sweep; honoured only in IDLE or DONE.
- dut_sum  in  WIDTH+1  sum returned by the adder under test, as {cout, s}.
- op_a  out  WIDTH  operand a driven to the adder under test.
- op_b  out  WIDTH  operand b driven to the adder under test.
- busy  out  1  high in DRIVE and CHECK.
- done  out  1  high in DONE.
- pass  out  1  valid while done is high; 1 when err_count is 0.
- err_count  out  2*WIDTH+1  number of mismatching vectors.
- fail_valid  out  1  set when the first mismatch is captured.
- fail_a, fail_b  out  WIDTH  operands of the first mismatch.
- fail_sum  out  WIDTH+1  dut_sum value observed at the first mismatch.

## Operation
- Reset value of every output is 0. The FSM resets to IDLE.
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE or DONE with start=1: next state is DRIVE. In the same transition the vector counter, err_count, fail_* and fail_valid are all cleared.
- DRIVE: hold op_a and op_b for SETTLE cycles using a settle counter, then go to CHECK.
- CHECK, single cycle:
  - Compare dut_sum with the golden sum, {1'b0,op_a} + {1'b0,op_b}, which is (WIDTH+1)-bit with no truncation.
  - On a mismatch, increment err_count.
  - If fail_valid is 0 on that mismatch, capture fail_a, fail_b and fail_sum, and set fail_valid.
  - If the vector counter is at its last value, go to DONE. Otherwise increment the counter and go to DRIVE.
- Vector counter is 2*WIDTH bits, with op_a = counter[2W-1:W] and op_b = counter[W-1:0].
  - Order is a outer, b inner: (0,0), (0,1) … (0,15), (1,0) … (15,15).
  - There is no wrap: the sweep always ends at the all-ones vector.
- err_count can hold up to 2^(2W), which is every vector failing, so it never saturates.
- DONE: op_a and op_b hold the last vector driven. Results hold until the next start or rst.
- start during DRIVE or CHECK is ignored, with no restart and no effect on results.
- rst during a sweep asynchronously returns every output and the FSM to their reset values. The partial sweep is discarded.

## Timing
- A start sampled at edge N puts the FSM in DRIVE after edge N, with op_a=op_b=0.
- Each vector occupies SETTLE+1 cycles (SETTLE in DRIVE, 1 in CHECK).
- dut_sum is sampled at the CHECK cycle's clock edge.
- For a full sweep, done rises 2^(2W)·(SETTLE+1) cycles after start is accepted. For the defaults that is 768 cycles.
- err_count and fail_* update on the edge that ends CHECK.
- busy and done are registered outputs, decoded from the state register.

## Configuration
- HALT_ON_ERROR_EN defined: the first mismatch in CHECK transitions to DONE instead of advancing.
  - op_a and op_b hold the failing vector.
  - err_count is 1.
- HALT_ON_ERROR_EN undefined: the full sweep always completes, and err_count holds the total number of mismatches.

## Structure
- Shared package adder_chk_pkg holds:
  - state encodings for IDLE, DRIVE, CHECK and DONE;
  - default WIDTH and SETTLE;
  - the SETTLE counter width constant (4 bits).
- One sub-module, ref_adder: a purely combinational WIDTH-bit golden adder producing the WIDTH+1 sum. It is instantiated once.

## Test plan
- Ideal behavioural adder, defaults, start pulse → done after 768 cycles, pass=1, err_count=0, fail_valid=0, op_a=op_b=15.
- Adder with s[0] stuck at 0 → err_count=128, fail_a=0, fail_b=1, fail_sum=5'b00000, pass=0.
- Adder with cout stuck at 0 → err_count=120, fail_a=1, fail_b=15, fail_sum=5'b00000.
- HALT_ON_ERROR_EN with s[0] stuck at 0 → done 6 cycles after start is accepted, err_count=1, op_a=0, op_b=1.
- rst asserted mid-sweep at vector (3,7) → all outputs 0 immediately, FSM in IDLE. A fresh start with an ideal adder gives pass=1.
- start re-pulsed at cycle 100 of a sweep → ignored, and done still rises at cycle 768. start in DONE → counters clear and a new sweep begins.
